// File: rtl/i2s_rx_axis_if.sv
// i2s_rx_axis_if: AXI4-Stream bus carrying 16-bit left-channel PCM samples
interface i2s_rx_axis_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/i2s_rx_axis.sv
// i2s_rx_axis: I2S master receiver, left channel into a FWFT FIFO with AXI4-Stream output
module i2s_rx_axis #(
    parameter int BCLK_HALF  = 49,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 160
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         i2s_bclk,
    output logic                         i2s_lrck,
    input  logic                         i2s_sdin,
    i2s_rx_axis_if.master                m_axis,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                   ovf_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;

    logic [6:0]    div_cnt;
    logic [4:0]    bit_cnt;
    logic [4:0]    bit_nxt;
    logic          sd_s1;
    logic          sd_s2;
    logic [15:0]   shreg;
    logic [15:0]   word;
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic          mem_l [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] frm_cnt;
    logic          tick;
    logic          rise;
    logic          fall;
    logic          data_bit;
    logic          word_done;
    logic          valid;
    logic          pop;
    logic          full;
    logic          push;
    logic          frame_end;

    assign tick      = en && div_cnt == 7'(BCLK_HALF - 1);
    assign rise      = tick && !i2s_bclk;
    assign fall      = tick && i2s_bclk;
    assign bit_nxt   = bit_cnt + 5'd1;
    assign data_bit  = rise && bit_cnt != 5'd0 && (bit_cnt <= 5'd16);
    assign word_done = rise && bit_cnt == 5'd16;
    assign word      = {shreg[14:0], sd_s2};
    assign valid     = fifo_level != '0;
    assign pop       = valid && m_axis.tready;
    assign full      = fifo_level == (AW + 1)'(FIFO_DEPTH);
    assign push      = word_done && (!full || pop);
    assign frame_end = frm_cnt == FW'(FRAME_LEN - 1);

    // Head entry is shown directly; zero while empty so reset leaves the bus quiet
    assign m_axis.tvalid = valid;
    assign m_axis.tdata  = valid ? mem_d[rd_ptr] : 16'd0;
    assign m_axis.tlast  = valid ? mem_l[rd_ptr] : 1'b0;

    // Bit clock divider: wrap at BCLK_HALF-1 and toggle BCLK, parked low while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else begin
            div_cnt  <= tick ? 7'd0 : div_cnt + 7'd1;
            i2s_bclk <= i2s_bclk ^ tick;
        end
    end

    // Bit position advances on BCLK falls; LRCK follows its MSB on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            i2s_lrck <= 1'b0;
        end else if (!en) begin
            bit_cnt  <= '0;
            i2s_lrck <= 1'b0;
        end else if (fall) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= bit_nxt[4];
        end
    end

    // Two-flop synchronizer for the codec data line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_s1 <= 1'b0;
            sd_s2 <= 1'b0;
        end else begin
            sd_s1 <= i2s_sdin;
            sd_s2 <= sd_s1;
        end
    end

    // Left-channel shift register, MSB first, one BCLK after the LRCK edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (!en) begin
            shreg <= '0;
        end else if (data_bit) begin
            shreg <= word;
        end
    end

    // FIFO pointers, occupancy, frame position and overflow count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            frm_cnt    <= '0;
            ovf_cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                frm_cnt <= frame_end ? '0 : frm_cnt + FW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
            if (word_done && !push && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    // Sample storage; a full FIFO being popped overwrites the departing head slot
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr] <= word;
            mem_l[wr_ptr] <= frame_end;
        end
    end
endmodule

// File: tb/tb_i2s_rx_axis.sv
// tb_i2s_rx_axis: codec model plus queue-based reference for the I2S receiver
module tb_i2s_rx_axis;
    localparam int BH    = 49;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        sdin  = 1'b0;
    logic        bclk;
    logic        lrck;
    logic [3:0]  level;
    logic [7:0]  ovf;

    i2s_rx_axis_if axis ();

    i2s_rx_axis #(.BCLK_HALF(BH), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .i2s_bclk   (bclk),
        .i2s_lrck   (lrck),
        .i2s_sdin   (sdin),
        .m_axis     (axis),
        .fifo_level (level),
        .ovf_cnt    (ovf)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [16:0] mq[$];
    logic [15:0] tx_l[$];
    logic [15:0] tx_r[$];
    logic [15:0] sent[$];
    logic [15:0] beat_d[$];
    logic        beat_l[$];
    logic [15:0] cur_l = '0;
    logic [15:0] cur_r = '0;
    int          m_ovf = 0;
    int          m_fc = 0;
    int          pos = 0;
    int          ph;
    int          ndone = 0;
    int          nf16 = 0;
    int          f16_cyc = 0;
    logic        bprev = 1'b0;
    logic        en_at = 1'b0;
    logic        pend_pop = 1'b0;
    logic        done;
    logic        acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // sel: 0 bclk==v, 1 lrck==v, 2 beats>=v, 3 completions>=v, 4 ph16 falls>v, 5 bit 8 high
    task automatic wait_until(input int sel, input int v, input int lim, input string tag);
        int i;
        logic hit;
        for (i = 0; i < lim; i++) begin
            if (sel == 0) hit = int'(bclk) == v;
            else if (sel == 1) hit = int'(lrck) == v;
            else if (sel == 2) hit = beat_d.size() >= v;
            else if (sel == 3) hit = ndone >= v;
            else if (sel == 4) hit = nf16 > v;
            else hit = pos == 8 && bclk === 1'b1;
            if (hit) break;
            step();
        end
        chk(tag, i < lim, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bclk"}, bclk, 0);
        chk({tag, "_lrck"}, lrck, 0);
        chk({tag, "_tvalid"}, axis.tvalid, 0);
        chk({tag, "_tlast"}, axis.tlast, 0);
        chk({tag, "_tdata"}, axis.tdata, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    // Codec and stream reference: codec shifts on BCLK falls, samples complete after 16 left bits
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_fc = 0;
            pos = 0;
            bprev = 1'b0;
            en_at = 1'b0;
            pend_pop = 1'b0;
        end else begin
            done = 1'b0;
            if (en_at) begin
                if (!bprev && bclk && pos % 32 == 16) done = 1'b1;
                if (bprev && !bclk) begin
                    pos++;
                    ph = pos % 32;
                    if (ph == 1) begin
                        cur_l = tx_l.size() > 0 ? tx_l.pop_front() : 16'($urandom);
                        cur_r = tx_r.size() > 0 ? tx_r.pop_front() : 16'($urandom);
                    end
                    if (ph == 16) begin
                        nf16++;
                        f16_cyc = cyc;
                    end
                    sdin = (ph >= 1 && ph <= 16) ? cur_l[16 - ph] : cur_r[(32 - ph) % 32];
                end
                bprev = bclk;
            end else begin
                pos = 0;
                bprev = 1'b0;
            end
            acc = mq.size() < DEPTH || pend_pop;
            if (pend_pop) void'(mq.pop_front());
            if (done) begin
                ndone++;
                sent.push_back(cur_l);
                if (acc) begin
                    mq.push_back({m_fc == FLEN - 1, cur_l});
                    m_fc = (m_fc + 1) % FLEN;
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
            end
            if (done || pend_pop) begin
                chk("level", level, mq.size());
                chk("ovf", ovf, m_ovf);
                chk("tvalid", axis.tvalid, mq.size() != 0);
            end
            pend_pop = axis.tvalid && axis.tready;
            if (pend_pop) begin
                chk("pop_valid", axis.tvalid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("beat_tdata", axis.tdata, mq[0][15:0]);
                    chk("beat_tlast", axis.tlast, mq[0][16]);
                end
                beat_d.push_back(axis.tdata);
                beat_l.push_back(axis.tlast);
            end
            en_at = en;
        end
    end

    int t1, t2, c0, nb0, s0, d0, nb, s;

    initial begin
        axis.tready = 1'b0;
        tx_l.push_back(16'h8001);
        tx_r.push_back(16'h7FFF);
        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (120) step();
        chk("idle_bclk", bclk, 0);
        chk("idle_level", level, 0);

        // Basic capture, BCLK and LRCK periods
        en = 1'b1;
        axis.tready = 1'b1;
        wait_until(0, 0, 200, "bclk_lo");
        wait_until(0, 1, 200, "bclk_hi");
        t1 = cyc;
        wait_until(0, 0, 200, "bclk_lo2");
        wait_until(0, 1, 200, "bclk_hi2");
        t2 = cyc;
        chk("bclk_period", t2 - t1, 2 * BH);
        wait_until(2, 1, 4000, "first_beat");
        chk("first_tdata", beat_d[0], 16'h8001);
        repeat (100) step();
        chk("one_beat", beat_d.size(), 1);
        wait_until(1, 0, 4000, "lrck_lo");
        wait_until(1, 1, 4000, "lrck_hi");
        t1 = cyc;
        wait_until(1, 0, 4000, "lrck_lo2");
        wait_until(1, 1, 4000, "lrck_hi2");
        t2 = cyc;
        chk("lrck_period", t2 - t1, 64 * BH);

        // Fresh start, then back-pressure for 10 samples
        rst_n = 1'b0;
        en = 1'b0;
        axis.tready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        nb0 = beat_d.size();
        s0 = sent.size();
        d0 = ndone;
        en = 1'b1;
        wait_until(3, d0 + 10, 33000, "ten_words");
        step();
        chk("bp_level", level, DEPTH);
        chk("bp_ovf", ovf, 2);

        // Word completes on the same cycle a full FIFO is popped
        wait_until(4, nf16, 4000, "ph16_fall");
        while (cyc < f16_cyc + BH - 1) step();
        axis.tready = 1'b1;
        step();
        axis.tready = 1'b0;
        step();
        chk("fullpop_level", level, DEPTH);
        chk("fullpop_ovf", ovf, 2);
        chk("fullpop_done", ndone, d0 + 11);
        chk("fullpop_beats", beat_d.size(), nb0 + 1);

        // One more drop, then drain and check order and tlast
        wait_until(3, d0 + 12, 4000, "twelfth_word");
        step();
        chk("ovf3_ovf", ovf, 3);
        chk("ovf3_level", level, DEPTH);
        axis.tready = 1'b1;
        wait_until(2, nb0 + 9, 50, "drain");
        axis.tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("drain_data", beat_d[nb0 + i], sent[s0 + (i < 8 ? i : 10)]);
            chk("drain_last", beat_l[nb0 + i], i == 3 || i == 7);
        end

        // Queue five entries, then pulse reset
        wait_until(3, d0 + 17, 17000, "five_words");
        step();
        chk("pre_rst_level", level, 5);
        chk("pre_rst_ovf", ovf, 3);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (3) step();
        rst_n = 1'b1;
        axis.tready = 1'b1;
        nb = beat_d.size();
        repeat (20) step();
        chk("no_stale_beat", beat_d.size(), nb);
        chk("no_stale_valid", axis.tvalid, 0);

        // Disable mid-word at bit 8, then re-enable
        en = 1'b1;
        wait_until(5, 0, 2000, "bit8");
        en = 1'b0;
        nb = beat_d.size();
        step();
        chk("dis_bclk", bclk, 0);
        chk("dis_lrck", lrck, 0);
        repeat (1200) step();
        chk("dis_no_beat", beat_d.size(), nb);
        chk("dis_level", level, 0);
        s = sent.size();
        en = 1'b1;
        c0 = cyc;
        wait_until(0, 1, 200, "reen_hi");
        wait_until(0, 0, 200, "reen_lo");
        chk("reen_first_fall", cyc - c0, 2 * BH);
        wait_until(2, nb + 1, 3500, "reen_beat");
        if (sent.size() > s)
            chk("reen_data", beat_d[nb], sent[s]);
        else
            chk("reen_sent", sent.size(), s + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx_axis.md
I2S_RX_AXIS -- requirements
Module: i2s_rx_axis

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 49: clk cycles per BCLK half-period, valid range 2..127.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries, a power of two, range 2..64.
REQ-003 SHALL have parameter FRAME_LEN, default 160: samples per tlast frame (hop length).
REQ-004 SHALL have port clk, input, 1 bit: single system clock (50 MHz); all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: receiver enable.
REQ-007 SHALL have port i2s_bclk, output, 1 bit: bit clock, registered.
REQ-008 SHALL have port i2s_lrck, output, 1 bit: word select, registered; 0 = left.
REQ-009 SHALL have port i2s_sdin, input, 1 bit: serial data from the codec, asynchronous to clk.
REQ-010 SHALL have port m_axis_tdata, output, 16 bits: left-channel PCM sample, signed, MSB first on the wire.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit; port m_axis_tready, input, 1 bit; port m_axis_tlast, output, 1 bit.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port ovf_cnt, output, 8 bits: count of dropped samples, saturating at 255.

Function
REQ-014 SHALL generate no derived clocks; BCLK timing is produced only by clk-domain events.
- div_cnt runs 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps and toggles i2s_bclk.
- A 0->1 toggle is a rise event; a 1->0 toggle is a fall event.
REQ-015 SHALL pass i2s_sdin through a 2-flop synchronizer; the synchronized value is sampled on each rise event.
REQ-016 SHALL maintain bit_cnt (5 bits), incremented on each fall event and wrapping 31->0.
- i2s_lrck = registered bit_cnt[4], so it changes only on fall events.
REQ-017 SHALL use the standard one-bit I2S delay.
- Rise events with bit_cnt 1..16 shift in left bits 15..0, MSB first.
- On the rise event with bit_cnt==16 the 16-bit word is complete.
- Right-channel bits are ignored.
REQ-018 SHALL, when a word completes and the FIFO is not full, write the word to the FIFO in that same cycle.
REQ-019 SHALL, when a word completes and the FIFO is full, drop the word and increment ovf_cnt (saturating at 255).
- The FIFO contents SHALL remain unchanged.
REQ-020 SHALL implement the FIFO as first-word-fall-through.
- m_axis_tvalid = (level != 0).
- m_axis_tdata shows the head entry.
- Pop occurs on tvalid && tready.
REQ-021 SHALL, on a simultaneous push and pop, keep level unchanged; a full FIFO with a pop in the same cycle accepts the push (no overflow).
REQ-022 SHALL keep tdata/tlast stable while tvalid && !tready (AXI4-Stream rule).
REQ-023 SHALL store a tlast bit with each entry.
- Set when the accepted-sample counter (0..FRAME_LEN-1) equals FRAME_LEN-1; that counter then wraps to 0.
- Dropped samples do not advance the counter.
REQ-024 SHALL, when en=0, hold div_cnt=0, bit_cnt=0, i2s_bclk=0, i2s_lrck=0 and the shift register cleared, with no pushes.
- The FIFO continues to drain.
- ovf_cnt and the frame counter hold their values.
REQ-025 SHALL, on en 0->1, start with div_cnt=0; the first fall event is reached after 2*BCLK_HALF cycles.
REQ-026 SHALL, on en 1->0 mid-word, discard the partial word.
REQ-027 SHALL, with defaults, produce BCLK = 50 MHz/98 ≈ 510.2 kHz and LRCK ≈ 15.94 kHz.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force i2s_bclk=0, i2s_lrck=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fifo_level=0, ovf_cnt=0, and clear all counters, synchronizer flops and FIFO pointers.
REQ-029 SHALL keep the block idle after reset deassertion until en=1; reset asserted mid-word or mid-frame discards all state.

Verification
REQ-030 SHALL be verified with a bench covering the following directed scenarios:
- en=1, tready=1, codec model sends left=16'h8001, right=16'h7FFF: exactly one beat, tdata=16'h8001; BCLK period 98 clk; LRCK period 3136 clk.
- tready=0 for 10 frames with FIFO_DEPTH=8: level stops at 8; ovf_cnt=2; the 8 oldest samples emerge in order once tready=1.
- FRAME_LEN=4, tready=1, 9 samples: tlast set on beats 4 and 8 only.
- FIFO full, a word completes in the same cycle as a pop: level stays 8; ovf_cnt unchanged; the new sample is stored.
- en dropped at bit_cnt==8: no beat produced; BCLK/LRCK go low next cycle; re-enable gives a first fall event after 98 cycles and the next word is correct.
- rst_n pulsed low for 3 cycles with 5 entries queued and ovf_cnt=3: all outputs return to reset values immediately; no stale beat appears after release.
